// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared types and defaults for the unified-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_IF = 3'd1,
    GNT_DM = 3'd2,
    RSP_IF = 3'd3,
    RSP_DM = 3'd4
  } arb_state_t;

  // Saturating increment used by the fetch-starvation counter.
  function automatic logic [3:0] satInc(input logic [3:0] value, input logic [3:0] limit);
    return (value < limit) ? value + 4'd1 : limit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch/data request ports, memory-side bus and stall outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              stall_if;
  logic              stall_dm;

  // master: requesters plus memory array; slave: the arbiter serving them.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, dm_rdata, dm_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, dm_rdata, dm_done,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between fetch and data ports,
//               data first, with a starvation limit guaranteeing fetch progress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W       = cpu_mem_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  arb_state_t        r_state;
  logic [3:0]        r_starveCnt;
  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dmRdata;
  logic              r_ifDone;
  logic              r_dmDone;

  logic              w_dmWins;
  logic              w_grant;
  logic              w_pickPort;
  logic [3:0]        w_starveNext;

  // Data wins unless fetch is waiting and has already lost STARVE_LIMIT times in a row.
  assign w_dmWins   = bus.dm_req & (~bus.if_req | (r_starveCnt < C_STARVE_LIMIT));
  assign w_grant    = w_dmWins | bus.if_req;
  assign w_pickPort = w_dmWins ? PORT_DM : PORT_IF;

  always_comb begin
    w_starveNext = 4'd0;
    if (w_pickPort == PORT_DM && bus.if_req) begin
      w_starveNext = satInc(r_starveCnt, C_STARVE_LIMIT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_starveCnt <= 4'd0;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_ifRdata   <= '0;
      r_dmRdata   <= '0;
      r_ifDone    <= 1'b0;
      r_dmDone    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_memReq    <= 1'b1;
            r_starveCnt <= w_starveNext;
            if (w_pickPort == PORT_DM) begin
              r_state    <= GNT_DM;
              r_memAddr  <= bus.dm_addr;
              r_memWdata <= bus.dm_wdata;
              r_memWe    <= bus.dm_we;
            end else begin
              r_state    <= GNT_IF;
              r_memAddr  <= bus.if_addr;
              r_memWdata <= '0;
              r_memWe    <= 1'b0;
            end
          end
        end
        GNT_IF: begin
          if (bus.mem_ready) begin
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_ifRdata <= bus.mem_rdata;
            r_ifDone  <= 1'b1;
            r_state   <= RSP_IF;
          end
        end
        GNT_DM: begin
          if (bus.mem_ready) begin
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
            // Stores leave the last load value visible to the pipeline.
            if (!r_memWe) begin
              r_dmRdata <= bus.mem_rdata;
            end
            r_dmDone <= 1'b1;
            r_state  <= RSP_DM;
          end
        end
        RSP_IF: begin
          r_ifDone <= 1'b0;
          r_state  <= IDLE;
        end
        RSP_DM: begin
          r_dmDone <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_memReq;
  assign bus.mem_we    = r_memWe;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.if_rdata  = r_ifRdata;
  assign bus.dm_rdata  = r_dmRdata;
  assign bus.if_done   = r_ifDone;
  assign bus.dm_done   = r_dmDone;
  assign bus.stall_if  = bus.if_req & ~r_ifDone;
  assign bus.stall_dm  = bus.dm_req & ~r_dmDone;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and randomized bench for mem_port_arbiter against a
//               transaction-level arbitration and memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current access owner, its fields, and the visible read data.
  int          busyPhase;
  bit          ownerDm;
  logic [31:0] ownerAddr;
  logic [31:0] ownerWdata;
  logic        ownerWe;
  bit          readyDriven;
  logic [31:0] readyData;
  int          dmStreak;
  logic [31:0] expIfRdata;
  logic [31:0] expDmRdata;

  int readyPct;
  int holdOff;
  int ifIssuePct;
  int dmIssuePct;

  logic [31:0] memArr [logic [31:0]];

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a[15:0], 16'h5A3C} ^ 32'h1357_0000;
  endfunction

  task automatic modelInit();
    busyPhase   = 0;
    readyDriven = 0;
    dmStreak    = 0;
    expIfRdata  = '0;
    expDmRdata  = '0;
  endtask

  task automatic issueIf(input logic [31:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic issueDm(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
  endtask

  // Called just after a clock edge: predicts what that edge must have produced.
  task automatic modelCheck();
    logic sIf, sDm;
    bit   eReq, eIfDone, eDmDone;
    sIf     = bus.if_req;
    sDm     = bus.dm_req;
    eReq    = 0;
    eIfDone = 0;
    eDmDone = 0;
    if (busyPhase == 0) begin
      if (sDm && (!sIf || dmStreak < LIMIT)) begin
        ownerDm    = 1;
        ownerAddr  = bus.dm_addr;
        ownerWdata = bus.dm_wdata;
        ownerWe    = bus.dm_we;
        dmStreak   = sIf ? ((dmStreak < LIMIT) ? dmStreak + 1 : LIMIT) : 0;
        busyPhase  = 1;
        eReq       = 1;
      end else if (sIf) begin
        ownerDm    = 0;
        ownerAddr  = bus.if_addr;
        ownerWdata = '0;
        ownerWe    = 1'b0;
        dmStreak   = 0;
        busyPhase  = 1;
        eReq       = 1;
      end
    end else if (busyPhase == 1) begin
      if (readyDriven) begin
        if (ownerDm) begin
          eDmDone = 1;
          if (!ownerWe) expDmRdata = readyData;
        end else begin
          eIfDone    = 1;
          expIfRdata = readyData;
        end
        busyPhase = 2;
      end else begin
        eReq = 1;
      end
    end else begin
      busyPhase = 0;
    end

    expectEq("memReq", bus.mem_req, eReq);
    if (eReq) begin
      expectEq("memAddr", bus.mem_addr, ownerAddr);
      expectEq("memWe", bus.mem_we, ownerWe);
      if (ownerDm) expectEq("memWdata", bus.mem_wdata, ownerWdata);
    end else begin
      expectEq("memWeIdle", bus.mem_we, 1'b0);
    end
    expectEq("ifDone", bus.if_done, eIfDone);
    expectEq("dmDone", bus.dm_done, eDmDone);
    expectEq("ifRdata", bus.if_rdata, expIfRdata);
    expectEq("dmRdata", bus.dm_rdata, expDmRdata);
    expectEq("stallIf", bus.stall_if, sIf & ~eIfDone);
    expectEq("stallDm", bus.stall_dm, sDm & ~eDmDone);
  endtask

  // Memory array behaviour: ready is random (or held off); read data is the stored word.
  task automatic respond();
    bit rdy;
    if (bus.mem_req) begin
      if (holdOff > 0) begin
        rdy = 0;
        holdOff--;
      end else begin
        rdy = ($urandom_range(99) < readyPct);
      end
    end else begin
      rdy = 1'($urandom_range(1));
    end
    if (rdy && bus.mem_req && !bus.mem_we) bus.mem_rdata = memRead(bus.mem_addr);
    else                                   bus.mem_rdata = $urandom;
    if (rdy && bus.mem_req && bus.mem_we) memArr[bus.mem_addr] = bus.mem_wdata;
    bus.mem_ready = rdy;
    readyDriven   = (busyPhase == 1) && rdy;
    readyData     = bus.mem_rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelCheck();
    if (bus.if_done) bus.if_req = 1'b0;
    if (bus.dm_done) bus.dm_req = 1'b0;
    if (!bus.if_req && $urandom_range(99) < ifIssuePct)
      issueIf(32'($urandom_range(255)) << 2);
    if (!bus.dm_req && $urandom_range(99) < dmIssuePct)
      issueDm(1'($urandom_range(1)), 32'h1000 + (32'($urandom_range(15)) << 2), $urandom);
    respond();
  endtask

  task automatic waitDone(input bit dm, input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(dm ? bus.dm_done : bus.if_done) && n < 60);
    expectEq(tag, dm ? bus.dm_done : bus.if_done, 1'b1);
  endtask

  initial begin
    int n;
    int dmCount;

    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    readyPct      = 100;
    holdOff       = 0;
    ifIssuePct    = 0;
    dmIssuePct    = 0;
    modelInit();

    #12;
    expectEq("rstMemReq", bus.mem_req, 1'b0);
    expectEq("rstMemWe", bus.mem_we, 1'b0);
    expectEq("rstMemAddr", bus.mem_addr, 32'h0);
    expectEq("rstMemWdata", bus.mem_wdata, 32'h0);
    expectEq("rstIfRdata", bus.if_rdata, 32'h0);
    expectEq("rstDmRdata", bus.dm_rdata, 32'h0);
    expectEq("rstIfDone", bus.if_done, 1'b0);
    expectEq("rstDmDone", bus.dm_done, 1'b0);

    // Single fetch with memory always ready: done two cycles after the first sample.
    memArr[32'h40] = 32'h8C01_0004;
    issueIf(32'h40);
    reset = 1'b1;
    waitDone(0, "t1Done", n);
    expectEq("t1Latency", n, 2);
    expectEq("t1Rdata", bus.if_rdata, 32'h8C01_0004);

    // Simultaneous store and fetch: store first, load data untouched, then fetch.
    issueDm(1'b1, 32'h100, 32'hDEAD_BEEF);
    issueIf(32'h44);
    waitDone(1, "t2DmDone", n);
    expectEq("t2DmLatency", n, 3);
    expectEq("t2DmRdataKept", bus.dm_rdata, 32'h0);
    waitDone(0, "t2IfDone", n);
    expectEq("t2IfLatency", n, 3);
    expectEq("t2MemWrite", memRead(32'h100), 32'hDEAD_BEEF);

    // Continuous data traffic against a waiting fetch.
    issueIf(32'h80);
    issueDm(1'b0, 32'h1000, 32'h0);
    dmIssuePct = 100;
    dmCount    = 0;
    n          = 0;
    do begin
      tick();
      if (bus.dm_done) dmCount++;
      n++;
    end while (!bus.if_done && n < 80);
    expectEq("t3IfDone", bus.if_done, 1'b1);
    expectEq("t3DmCount", dmCount, LIMIT);
    dmIssuePct = 0;
    repeat (12) tick();

    // Load with three wait cycles.
    holdOff = 3;
    issueDm(1'b0, 32'h1100, 32'h0);
    waitDone(1, "t4Done", n);
    expectEq("t4Latency", n, 5);
    expectEq("t4Rdata", bus.dm_rdata, memRead(32'h1100));

    // Asynchronous reset while a fetch waits on memory.
    holdOff = 1000;
    issueIf(32'h200);
    repeat (2) tick();
    expectEq("t5Granted", bus.mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    expectEq("t5RstMemReq", bus.mem_req, 1'b0);
    expectEq("t5RstMemAddr", bus.mem_addr, 32'h0);
    expectEq("t5RstIfRdata", bus.if_rdata, 32'h0);
    expectEq("t5RstIfDone", bus.if_done, 1'b0);
    holdOff = 0;
    repeat (2) @(posedge clk);
    #1;
    modelInit();
    bus.mem_ready = 1'b0;
    issueIf(32'h240);
    reset = 1'b1;
    waitDone(0, "t5Done", n);
    expectEq("t5Latency", n, 2);
    expectEq("t5Rdata", bus.if_rdata, memRead(32'h240));

    // Randomized mixed traffic with random memory wait states.
    readyPct   = 60;
    ifIssuePct = 30;
    dmIssuePct = 40;
    repeat (1500) tick();
    ifIssuePct = 0;
    dmIssuePct = 0;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM, MEM stage).
- Sits between the PC/IFID fetch path, the EXMEM memory-stage path and the memory array.
- Grants one requester at a time and returns registered read data with a one-cycle done pulse.
- Drives per-port stall outputs that the hazard logic uses to hold PC, IFID and the later pipeline registers.
- DM normally has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, maximum consecutive DM grants while if_req is pending before IF is forced to win; must be 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held until if_done.
- if_addr  input  ADDR_W  fetch address; stable while if_req.
- if_rdata  output  DATA_W  fetched instruction; valid when if_done.
- if_done  output  1  one-cycle completion pulse.
- dm_req  input  1  data request; held until dm_done.
- dm_we  input  1  1 = write, 0 = read; stable while dm_req.
- dm_addr  input  ADDR_W  data address.
- dm_wdata  input  DATA_W  store data.
- dm_rdata  output  DATA_W  load data; valid when dm_done and the access is a read.
- dm_done  output  1  one-cycle completion pulse.
- mem_req  output  1  memory access request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid when mem_ready.
- mem_ready  input  1  memory completes the access this cycle.
- stall_if  output  1  combinational: if_req & ~if_done.
- stall_dm  output  1  combinational: dm_req & ~dm_done.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and starve_cnt to 0.
  - All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_done, dm_done.
  - An in-flight access is abandoned with no done pulse.
- FSM states: IDLE, GNT_IF, GNT_DM, RSP_IF, RSP_DM.
- IDLE arbitration, evaluated on every cycle spent in IDLE:
  - dm_req & (~if_req | starve_cnt < STARVE_LIMIT) -> GNT_DM.
  - else if_req -> GNT_IF.
  - else stay in IDLE.
- Entering GNT_x:
  - mem_req <= 1.
  - mem_addr and mem_wdata are latched from the granted port.
  - mem_we <= dm_we when x = DM, else 0.
- GNT_x with mem_ready=0: hold state; mem_req and all latched fields stay stable.
- GNT_x with mem_ready=1:
  - mem_req <= 0 and mem_we <= 0.
  - x_rdata <= mem_rdata, except on DM writes, where dm_rdata keeps its previous value.
  - x_done <= 1; state goes to RSP_x.
- RSP_x: x_done is high for exactly this cycle. The next state is IDLE with no arbitration in RSP, so a completed requester whose req is still high in its done cycle is never re-granted for the same access.
- Latency: request first sampled in IDLE at cycle N.
  - mem_req is high at N+1.
  - With mem_ready high at N+1, done is high at N+2.
  - Minimum 3 cycles per access; each mem_ready wait cycle adds 1.
- Starvation counter:
  - On a DM grant with if_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On a DM grant with if_req=0: starve_cnt clears to 0.
  - On an IF grant: starve_cnt clears to 0.
- x_rdata holds its value between accesses.
- mem_ready while in IDLE or RSP_x is ignored.
- A requester dropping req mid-grant is a protocol violation. The arbiter still completes the access and pulses done.
- stall_x is combinational from the input req and the registered done.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the arb_state_t enum (IDLE, GNT_IF, GNT_DM, RSP_IF, RSP_DM);
  - ADDR_W and DATA_W defaults;
  - the port-select constants PORT_IF and PORT_DM.
- No sub-module: a single FSM plus the starvation counter, all in one module.

Test Plan:
- Reset release; if_req=1, if_addr=0x40, mem_ready tied 1, mem_rdata=0x8C010004 -> mem_req high at cycle 1 with mem_addr=0x40; if_done plus if_rdata=0x8C010004 at cycle 2; stall_if high cycles 0-1.
- Both requests in the same cycle: dm_req write, dm_addr=0x100, dm_wdata=0xDEADBEEF; if_req pending -> DM granted first with mem_we=1 and mem_wdata=0xDEADBEEF; IF granted after RSP_DM; dm_rdata unchanged.
- dm_req held continuously with if_req pending, STARVE_LIMIT=4 -> exactly 4 DM completions, then an IF grant, then starve_cnt=0.
- DM read with mem_ready low for 3 cycles -> mem_req, mem_addr and mem_we=0 stable for 4 cycles; dm_done one cycle after mem_ready rises; dm_rdata=mem_rdata.
- reset asserted during GNT_IF while mem_ready=0 -> mem_req=0 immediately (asynchronous); no if_done after release; a new if_req is re-arbitrated from IDLE.
- Requester holds if_req high through its done cycle -> no second mem_req for that address until a fresh IDLE sample.
